// File: rtl/noc_link_fifo_pkg.sv
// noc_link_fifo_pkg: shared flit width and link FIFO depth for mesh generators
package noc_link_fifo_pkg;
  localparam int TOTAL_WIDTH = 32;
  localparam int DATA_WIDTH = TOTAL_WIDTH;
  localparam int LINK_FIFO_DEPTH = 4;
endpackage

// File: rtl/noc_link_fifo.sv
// noc_link_fifo: FWFT elastic link buffer with registered ready/valid; upstream i_valid/i_data/o_ready, downstream o_valid/o_data/i_ready, occupancy o_count
module noc_link_fifo
  import noc_link_fifo_pkg::*;
#(
  parameter int DATA_W = TOTAL_WIDTH,
  parameter int DEPTH = LINK_FIFO_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_count
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  logic [CNT_W-1:0] next_count;
  assign push = i_valid & o_ready;
  assign pop = o_valid & i_ready;
  assign o_data = mem[rd_ptr];
  always_comb next_count = o_count + CNT_W'(push) - CNT_W'(pop);
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= i_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      o_count <= next_count;
      o_valid <= next_count != '0;
      o_ready <= next_count != CNT_W'(DEPTH);
    end
`ifndef SYNTHESIS
  a_data_stable: assert property (@(posedge clk) disable iff (rst) i_valid && !o_ready |=> $stable(i_data));
  a_count_max: assert property (@(posedge clk) o_count <= CNT_W'(DEPTH));
`endif
endmodule
